// File: rtl/msi_directory_controller.sv
// MSI directory for NUM_PROCS L1 channels. It keeps a per-line state, sharer vector and owner,
// serialises one request at a time, and sends invalidates or downgrades before it grants a line.
//
// state   | meaning
// IDLE    | ReqReady high, waiting for a request
// LOOKUP  | read the directory entry and choose the path
// INVAL   | invalidate/downgrade pulse issued, collecting acks
// WB_WAIT | waiting for the owner's write-back and the remaining acks
// MEM_RD  | memory read strobe; data returns in the next cycle
// MEM_WR  | memory write strobe (write-back or dirty Put)
// RESP    | response pulse and directory entry update
module msi_directory_controller #(
  parameter int NUM_PROCS = 2,
  parameter int PID_W     = 1,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic [PID_W-1:0]     ReqProc,
  input  logic [1:0]           ReqType,
  input  logic [ADDR_W-1:0]    ReqAddr,
  input  logic [DATA_W-1:0]    ReqData,
  output logic                 RespValid,
  output logic [PID_W-1:0]     RespProc,
  output logic [2:0]           RespState,
  output logic [DATA_W-1:0]    RespData,
  output logic                 InvValid,
  output logic [NUM_PROCS-1:0] InvMask,
  output logic                 InvDowngrade,
  output logic [ADDR_W-1:0]    InvAddr,
  input  logic [NUM_PROCS-1:0] InvAck,
  input  logic                 WbValid,
  input  logic [DATA_W-1:0]    WbData,
  output logic                 MemRdEn,
  output logic                 MemWrEn,
  output logic [ADDR_W-1:0]    MemAddr,
  output logic [DATA_W-1:0]    MemWrData,
  input  logic [DATA_W-1:0]    MemRdData,
  output logic                 Busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [2:0] ST_I = 3'b001, ST_S = 3'b010, ST_M = 3'b011;
  localparam logic [1:0] T_GETS = 2'b00, T_GETM = 2'b01, T_PUT = 2'b10;
  localparam logic [NUM_PROCS-1:0] ONE = NUM_PROCS'(1);
  localparam logic [PID_W:0] NP = (PID_W+1)'(NUM_PROCS);

  typedef enum logic [2:0] {IDLE, LOOKUP, INVAL, WB_WAIT, MEM_RD, MEM_WR, RESP} stateT;

  stateT state, nextState;

  logic [2:0]           dirState   [DEPTH];
  logic [NUM_PROCS-1:0] dirSharers [DEPTH];
  logic [PID_W-1:0]     dirOwner   [DEPTH];

  logic [PID_W-1:0]     rProc;
  logic [1:0]           rType;
  logic [ADDR_W-1:0]    rAddr;
  logic [DATA_W-1:0]    rData;
  logic [NUM_PROCS-1:0] pending;
  logic                 downgrade, invFirst, wbGot;
  logic [DATA_W-1:0]    wbDataQ;
  logic [PID_W-1:0]     holdProc;
  logic [2:0]           holdState;
  logic [DATA_W-1:0]    holdData;

  logic [2:0]           entState;
  logic [NUM_PROCS-1:0] entSharers, pBit, ownerBit, lookupPend, pendNext, putSharers;
  logic [PID_W-1:0]     entOwner;
  logic                 isM, ownerIsReq, otherOwner, badReq;
  logic [2:0]           respStateNow;
  logic [DATA_W-1:0]    respDataNow;
  logic                 dirWe;
  logic [2:0]           newState;
  logic [NUM_PROCS-1:0] newSharers;
  logic [PID_W-1:0]     newOwner;

  // The entry cannot change between LOOKUP and RESP, so every later state re-reads it.
  assign entState   = dirState[rAddr];
  assign entSharers = dirSharers[rAddr];
  assign entOwner   = dirOwner[rAddr];
  assign isM        = (entState == ST_M);
  assign ownerIsReq = (entOwner == rProc);
  assign otherOwner = isM && !ownerIsReq;
  assign pBit       = ONE << rProc;
  assign ownerBit   = ONE << entOwner;
  assign badReq     = (rType == 2'b11) || ({1'b0, rProc} >= NP);
  assign lookupPend = (rType == T_GETS || otherOwner) ? ownerBit : (entSharers & ~pBit);
  assign pendNext   = pending & ~InvAck;
  assign putSharers = entSharers & ~pBit;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (ReqValid) nextState = LOOKUP;
      LOOKUP: begin
        if (badReq)                nextState = RESP;
        else if (rType == T_GETS)  nextState = otherOwner ? INVAL : (isM ? RESP : MEM_RD);
        else if (rType == T_GETM)  nextState = (lookupPend != '0) ? INVAL : RESP;
        else                       nextState = (isM && ownerIsReq) ? MEM_WR : RESP;
      end
      INVAL: begin
        if (otherOwner)            nextState = WB_WAIT;
        else if (pendNext == '0)   nextState = RESP;
      end
      WB_WAIT: if ((wbGot || WbValid) && pendNext == '0) nextState = MEM_WR;
      MEM_RD:  nextState = RESP;
      MEM_WR:  nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    respStateNow = ST_I;
    respDataNow  = '0;
    dirWe        = 1'b0;
    newState     = entState;
    newSharers   = entSharers;
    newOwner     = entOwner;
    if (!badReq) begin
      case (rType)
        T_GETS: begin
          respStateNow = (isM && ownerIsReq) ? ST_M : ST_S;
          respDataNow  = (isM && ownerIsReq) ? '0 : (isM ? wbDataQ : MemRdData);
          if (!(isM && ownerIsReq)) begin
            dirWe      = 1'b1;
            newState   = ST_S;
            newSharers = isM ? (ownerBit | pBit) : (entSharers | pBit);
          end
        end
        T_GETM: begin
          respStateNow = ST_M;
          respDataNow  = rData;
          dirWe        = 1'b1;
          newState     = ST_M;
          newOwner     = rProc;
          newSharers   = pBit;
        end
        T_PUT: begin
          if (isM && ownerIsReq) begin
            dirWe      = 1'b1;
            newState   = ST_I;
            newSharers = '0;
          end else if (entState == ST_S && (entSharers & pBit) != '0) begin
            dirWe      = 1'b1;
            newSharers = putSharers;
            newState   = (putSharers == '0) ? ST_I : ST_S;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state     <= IDLE;
      rProc     <= '0;
      rType     <= '0;
      rAddr     <= '0;
      rData     <= '0;
      pending   <= '0;
      downgrade <= 1'b0;
      invFirst  <= 1'b0;
      wbGot     <= 1'b0;
      wbDataQ   <= '0;
      holdProc  <= '0;
      holdState <= '0;
      holdData  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dirState[i]   <= '0;
        dirSharers[i] <= '0;
        dirOwner[i]   <= '0;
      end
    end else begin
      state <= nextState;
      if (state == IDLE && ReqValid) begin
        rProc <= ReqProc;
        rType <= ReqType;
        rAddr <= ReqAddr;
        rData <= ReqData;
        wbGot <= 1'b0;
      end
      if (state == LOOKUP) begin
        pending   <= lookupPend;
        downgrade <= (rType == T_GETS);
        invFirst  <= (nextState == INVAL);
      end else begin
        invFirst  <= 1'b0;
      end
      if (state == INVAL || state == WB_WAIT) begin
        pending <= pendNext;
        if (WbValid) begin
          wbGot   <= 1'b1;
          wbDataQ <= WbData;
        end
      end
      if (state == RESP) begin
        holdProc  <= rProc;
        holdState <= respStateNow;
        holdData  <= respDataNow;
        if (dirWe) begin
          dirState[rAddr]   <= newState;
          dirSharers[rAddr] <= newSharers;
          dirOwner[rAddr]   <= newOwner;
        end
      end
    end
  end

  assign ReqReady     = (state == IDLE);
  assign Busy         = (state != IDLE);
  assign RespValid    = (state == RESP);
  assign RespProc     = RespValid ? rProc : holdProc;
  assign RespState    = RespValid ? respStateNow : holdState;
  assign RespData     = RespValid ? respDataNow : holdData;
  assign InvValid     = invFirst;
  assign InvMask      = invFirst ? pending : '0;
  assign InvDowngrade = invFirst & downgrade;
  assign InvAddr      = invFirst ? rAddr : '0;
  assign MemRdEn      = (state == MEM_RD);
  assign MemWrEn      = (state == MEM_WR);
  assign MemAddr      = (MemRdEn || MemWrEn) ? rAddr : '0;
  assign MemWrData    = MemWrEn ? ((rType == T_PUT) ? rData : wbDataQ) : '0;

endmodule

// File: tb/tb_msi_directory_controller.sv
// Scoreboard bench for the MSI directory: directed requests push expected responses,
// invalidates and memory accesses; a negedge monitor pops and compares them.
module tb_msi_directory_controller;

  localparam logic [1:0] GS = 2'b00, GM = 2'b01, PT = 2'b10, RSV = 2'b11;
  localparam logic [2:0] SI = 3'b001, SS = 3'b010, SM = 3'b011;

  logic       Clock, ResetN, ReqValid, ReqReady;
  logic [2:0] ReqProc;
  logic [1:0] ReqType;
  logic [3:0] ReqAddr, ReqData;
  logic       RespValid;
  logic [2:0] RespProc, RespState;
  logic [3:0] RespData;
  logic       InvValid, InvDowngrade;
  logic [3:0] InvMask, InvAddr, InvAck;
  logic       WbValid;
  logic [3:0] WbData;
  logic       MemRdEn, MemWrEn;
  logic [3:0] MemAddr, MemWrData;
  logic [3:0] MemRdData = 4'h0;
  logic       Busy;

  msi_directory_controller #(.NUM_PROCS(4), .PID_W(3), .ADDR_W(4), .DATA_W(4)) dut (
    .Clock(Clock), .ResetN(ResetN), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqProc(ReqProc), .ReqType(ReqType), .ReqAddr(ReqAddr), .ReqData(ReqData),
    .RespValid(RespValid), .RespProc(RespProc), .RespState(RespState), .RespData(RespData),
    .InvValid(InvValid), .InvMask(InvMask), .InvDowngrade(InvDowngrade), .InvAddr(InvAddr),
    .InvAck(InvAck), .WbValid(WbValid), .WbData(WbData),
    .MemRdEn(MemRdEn), .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemWrData(MemWrData),
    .MemRdData(MemRdData), .Busy(Busy)
  );

  typedef struct { int proc; logic [2:0] st; logic [3:0] data; int cyc; } respE;
  typedef struct { logic [3:0] mask; logic dg; logic [3:0] addr; } invE;
  typedef struct { logic [3:0] addr; logic [3:0] data; int cyc; } memE;

  respE respQ[$];
  invE  invQ[$];
  memE  wrQ[$];
  memE  rdQ[$];
  respE monR;
  invE  monI;
  memE  monM;

  // Backing memory preload: line 1 = 1000, line 2 = 0011, line 4 = 0101.
  logic [3:0] tbMem [16] = '{4'h0, 4'h8, 4'h3, 4'h0, 4'h5, 4'h0, 4'h0, 4'h0,
                             4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic void expResp(int p, logic [2:0] s, logic [3:0] d, int c);
    respQ.push_back('{p, s, d, c});
  endfunction
  function automatic void expInv(logic [3:0] m, logic dg, logic [3:0] a);
    invQ.push_back('{m, dg, a});
  endfunction
  function automatic void expWr(logic [3:0] a, logic [3:0] d, int c);
    wrQ.push_back('{a, d, c});
  endfunction
  function automatic void expRd(logic [3:0] a, int c);
    rdQ.push_back('{a, 4'h0, c});
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, expv);
    end
  endfunction

  // Monitor: every DUT output event must match the head of its queue.
  always @(negedge Clock) begin
    if (RespValid) begin
      if (respQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected proc=%0d state=%b data=%b cyc=%0d", RespProc, RespState, RespData, cyc);
      end else begin
        monR = respQ.pop_front();
        checks++;
        if ({RespProc, RespState, RespData} !== {3'(monR.proc), monR.st, monR.data}) begin
          errors++;
          $display("FAIL resp_fields got=%0d/%b/%b want=%0d/%b/%b", RespProc, RespState, RespData,
                   monR.proc, monR.st, monR.data);
        end
        checks++;
        if (cyc != monR.cyc) begin
          errors++;
          $display("FAIL resp_cycle got=%0d want=%0d", cyc, monR.cyc);
        end
      end
    end
    if (InvValid) begin
      if (invQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL inv_unexpected mask=%b dg=%b addr=%h", InvMask, InvDowngrade, InvAddr);
      end else begin
        monI = invQ.pop_front();
        checks++;
        if ({InvMask, InvDowngrade, InvAddr} !== {monI.mask, monI.dg, monI.addr}) begin
          errors++;
          $display("FAIL inv_fields got=%b/%b/%h want=%b/%b/%h", InvMask, InvDowngrade, InvAddr,
                   monI.mask, monI.dg, monI.addr);
        end
      end
    end
    if (MemWrEn) begin
      if (wrQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL memwr_unexpected addr=%h data=%h", MemAddr, MemWrData);
      end else begin
        monM = wrQ.pop_front();
        checks++;
        if ({MemAddr, MemWrData} !== {monM.addr, monM.data} || cyc != monM.cyc) begin
          errors++;
          $display("FAIL memwr got=%h/%h@%0d want=%h/%h@%0d", MemAddr, MemWrData, cyc,
                   monM.addr, monM.data, monM.cyc);
        end
      end
      tbMem[MemAddr] = MemWrData;
    end
    if (MemRdEn) begin
      if (rdQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL memrd_unexpected addr=%h", MemAddr);
      end else begin
        monM = rdQ.pop_front();
        checks++;
        if (MemAddr !== monM.addr || cyc != monM.cyc) begin
          errors++;
          $display("FAIL memrd got=%h@%0d want=%h@%0d", MemAddr, cyc, monM.addr, monM.cyc);
        end
      end
      MemRdData = tbMem[MemAddr];
    end
  end

  task automatic issue(input int p, input logic [1:0] t, input logic [3:0] a, input logic [3:0] d,
                       output int acc);
    int g = 0;
    @(negedge Clock);
    while (!ReqReady && g < 200) begin
      @(negedge Clock);
      g++;
    end
    if (!ReqReady) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout got=0 want=1");
    end
    ReqValid = 1'b1;
    ReqProc  = 3'(p);
    ReqType  = t;
    ReqAddr  = a;
    ReqData  = d;
    acc      = cyc;
    @(posedge Clock);
    #1 ReqValid = 1'b0;
  endtask

  task automatic waitInv(output int c);
    int g = 0;
    @(negedge Clock);
    while (!InvValid && g < 50) begin
      @(negedge Clock);
      g++;
    end
    if (!InvValid) begin
      checks++; errors++;
      $display("FAIL inv_timeout got=0 want=1");
    end
    c = cyc;
  endtask

  task automatic ack(input logic [3:0] m, input int gap, output int t);
    repeat (gap) @(negedge Clock);
    InvAck = m;
    t = cyc;
    @(posedge Clock);
    #1 InvAck = 4'h0;
  endtask

  task automatic checkIdle(input string tag);
    chk({tag, "_ready"}, 32'(ReqReady), 1);
    chk({tag, "_busy"}, 32'(Busy), 0);
    chk({tag, "_strobes"}, 32'({RespValid, InvValid, MemRdEn, MemWrEn}), 0);
    chk({tag, "_resp"}, 32'({RespProc, RespState, RespData}), 0);
    chk({tag, "_inv"}, 32'({InvMask, InvDowngrade, InvAddr}), 0);
    chk({tag, "_mem"}, 32'({MemAddr, MemWrData}), 0);
  endtask

  initial begin
    int acc, c, t;
    ResetN = 1'b0; ReqValid = 1'b0; ReqProc = '0; ReqType = '0; ReqAddr = '0; ReqData = '0;
    InvAck = '0; WbValid = 1'b0; WbData = '0;
    repeat (3) @(negedge Clock);
    checkIdle("reset");
    ResetN = 1'b1;

    // P0 GetS line 1 from memory, then P1 joins as sharer without invalidation
    issue(0, GS, 4'h1, 4'h0, acc); expRd(4'h1, acc + 2); expResp(0, SS, 4'b1000, acc + 3);
    issue(1, GS, 4'h1, 4'h0, acc); expRd(4'h1, acc + 2); expResp(1, SS, 4'b1000, acc + 3);

    // P1 GetM: invalidate P0, response one cycle after the ack
    issue(1, GM, 4'h1, 4'b0110, acc); expInv(4'b0001, 1'b0, 4'h1);
    waitInv(c);
    chk("getm_inv_cycle", 32'(c), 32'(acc + 2));
    ack(4'b0001, 2, t); expResp(1, SM, 4'b0110, t + 1);

    // P0 GetS on M line: downgrade P1, write-back arrives before the ack
    issue(0, GS, 4'h1, 4'h0, acc); expInv(4'b0010, 1'b1, 4'h1);
    waitInv(c);
    @(negedge Clock); WbValid = 1'b1; WbData = 4'b0110;
    @(posedge Clock); #1 WbValid = 1'b0;
    ack(4'b0010, 2, t); expWr(4'h1, 4'b0110, t + 1); expResp(0, SS, 4'b0110, t + 2);

    // P2 GetM: both sharers ack in the same cycle as the invalidate
    issue(2, GM, 4'h1, 4'b1111, acc); expInv(4'b0011, 1'b0, 4'h1);
    waitInv(c);
    ack(4'b0011, 0, t); expResp(2, SM, 4'b1111, t + 1);

    // Three sharers on line 2, P3 GetM with staggered acks and a spurious P3 ack
    issue(0, GS, 4'h2, 4'h0, acc); expRd(4'h2, acc + 2); expResp(0, SS, 4'b0011, acc + 3);
    issue(1, GS, 4'h2, 4'h0, acc); expRd(4'h2, acc + 2); expResp(1, SS, 4'b0011, acc + 3);
    issue(2, GS, 4'h2, 4'h0, acc); expRd(4'h2, acc + 2); expResp(2, SS, 4'b0011, acc + 3);
    issue(3, GM, 4'h2, 4'b0101, acc); expInv(4'b0111, 1'b0, 4'h2);
    waitInv(c);
    ack(4'b0001, 1, t);
    ack(4'b1000, 1, t);
    ack(4'b0010, 1, t);
    ack(4'b0100, 2, t); expResp(3, SM, 4'b0101, t + 1);

    // Owner Put writes back; a second Put does nothing; a read then sees the new data
    issue(1, GM, 4'h8, 4'b1010, acc); expResp(1, SM, 4'b1010, acc + 2);
    issue(1, PT, 4'h8, 4'b1001, acc); expWr(4'h8, 4'b1001, acc + 2); expResp(1, SI, 4'h0, acc + 3);
    issue(1, PT, 4'h8, 4'b1001, acc); expResp(1, SI, 4'h0, acc + 2);
    issue(0, GS, 4'h8, 4'h0, acc); expRd(4'h8, acc + 2); expResp(0, SS, 4'b1001, acc + 3);
    // Last sharer Put empties the line, so the next GetM needs no invalidation
    issue(0, PT, 4'h8, 4'h0, acc); expResp(0, SI, 4'h0, acc + 2);
    issue(1, GM, 4'h8, 4'b0001, acc); expResp(1, SM, 4'b0001, acc + 2);

    // Reserved type and out-of-range processor
    issue(0, RSV, 4'h3, 4'hF, acc); expResp(0, SI, 4'h0, acc + 2);
    issue(5, GS, 4'h3, 4'h0, acc); expResp(5, SI, 4'h0, acc + 2);

    // Last directory entry, including an owner re-reading its own line
    issue(2, GM, 4'hF, 4'b1100, acc); expResp(2, SM, 4'b1100, acc + 2);
    issue(2, GS, 4'hF, 4'h0, acc); expResp(2, SM, 4'h0, acc + 2);
    issue(2, PT, 4'hF, 4'b1100, acc); expWr(4'hF, 4'b1100, acc + 2); expResp(2, SI, 4'h0, acc + 3);
    issue(0, GS, 4'hF, 4'h0, acc); expRd(4'hF, acc + 2); expResp(0, SS, 4'b1100, acc + 3);

    // Reset while waiting for a write-back
    issue(0, GM, 4'h4, 4'b0111, acc); expResp(0, SM, 4'b0111, acc + 2);
    issue(1, GS, 4'h4, 4'h0, acc); expInv(4'b0001, 1'b1, 4'h4);
    waitInv(c);
    repeat (2) @(negedge Clock);
    chk("busy_in_wb_wait", 32'(Busy), 1);
    ResetN = 1'b0;
    #1 checkIdle("midreset");
    @(negedge Clock); ResetN = 1'b1;
    issue(1, GS, 4'h4, 4'h0, acc); expRd(4'h4, acc + 2); expResp(1, SS, 4'b0101, acc + 3);
    issue(3, GM, 4'h1, 4'b1001, acc); expResp(3, SM, 4'b1001, acc + 2);

    repeat (8) @(negedge Clock);
    chk("resp_queue_drained", 32'(respQ.size()), 0);
    chk("inv_queue_drained", 32'(invQ.size()), 0);
    chk("memwr_queue_drained", 32'(wrQ.size()), 0);
    chk("memrd_queue_drained", 32'(rdQ.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
